// File: rtl/vx_mem_load_arb_pkg.sv
// Shared types and helpers for the memory-loader arbiter.
//   risc_v_data_type_t / risc_v_cacheline_t : payload of one load beat
//   mem_load_arb_state_e                    : arbiter FSM states
//   rr_pick()                               : round-robin next-index select
package vx_mem_load_arb_pkg;

  localparam int VX_MEM_LOAD_MAX_BURST = 16;
  localparam int CACHELINE_W           = 512;
  // rr_pick works on a fixed-width vector so it can serve any arbiter up to
  // this many requesters; callers zero-extend their valid vector.
  localparam int RR_MAX_REQS           = 8;

  typedef enum logic [1:0] {
    DT_INSTR = 2'd0,
    DT_DATA  = 2'd1,
    DT_KARGS = 2'd2,
    DT_RSVD  = 2'd3
  } risc_v_data_type_t;

  typedef logic [CACHELINE_W-1:0] risc_v_cacheline_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } mem_load_arb_state_e;

  // Return the first set bit of valid scanning last+1, last+2, ... modulo
  // num. The scan runs from the farthest candidate to the nearest so the
  // nearest valid index is the one left in pick. Returns last if none valid.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] last,
                                         input int         num);
    logic [2:0] pick;
    logic [2:0] idx;
    pick = last;
    for (int k = RR_MAX_REQS; k >= 1; k--) begin
      if (k <= num) begin
        idx = 3'((int'(last) + k) % num);
        if (valid[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/VX_mem_load_if.sv
// Handshake between a load producer (master) and the testbench memory
// loader (slave). A beat moves when load_valid && load_ready.
//   load_valid : master has a beat
//   data_type  : kind of image the cacheline belongs to
//   cacheline  : beat payload
//   load_ready : slave accepts the beat this cycle
interface VX_mem_load_if import vx_mem_load_arb_pkg::*; ();
  logic              load_valid;
  risc_v_data_type_t data_type;
  risc_v_cacheline_t cacheline;
  logic              load_ready;

  modport master (output load_valid, output data_type, output cacheline,
                  input  load_ready);
  modport slave  (input  load_valid, input  data_type, input  cacheline,
                  output load_ready);
endinterface

// File: rtl/vx_rr_pick.sv
// Combinational round-robin priority select.
//   valid_i : per-requester request
//   last_i  : index granted most recently (lowest priority next)
//   pick_o  : first valid index after last_i (last_i if none valid)
//   any_o   : at least one requester valid
module vx_rr_pick
  import vx_mem_load_arb_pkg::*;
#(
  parameter int NUM_REQS = 2,
  parameter int IDX_W    = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] valid_i,
  input  logic [IDX_W-1:0]    last_i,
  output logic [IDX_W-1:0]    pick_o,
  output logic                any_o
);

  assign pick_o = IDX_W'(rr_pick(8'(valid_i), 3'(last_i), NUM_REQS));
  assign any_o  = |valid_i;

endmodule

// File: rtl/vx_mem_load_arb.sv
// Round-robin burst arbiter sharing one memory-loader slave among NUM_REQS
// load requesters. A grant lasts until the requester's last beat or until
// MAX_BURST beats have been taken; the outgoing beat sits in a one-entry
// register that drives the master side of load_if.
//   clk, reset    : clock, asynchronous active-high reset
//   req_*         : per-requester valid/ready/last and beat payload
//   load_if       : master side toward the loader
//   busy          : a grant is open or a beat is still waiting to drain
//   grant_id      : current / most recent granted requester
//   xfer_count    : beats accepted by the loader since reset (wraps)
module vx_mem_load_arb
  import vx_mem_load_arb_pkg::*;
#(
  parameter int NUM_REQS  = 2,
  parameter int MAX_BURST = VX_MEM_LOAD_MAX_BURST,
  parameter int CNT_W     = 32,
  parameter int IDX_W     = $clog2(NUM_REQS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic              [NUM_REQS-1:0]    req_valid,
  output logic              [NUM_REQS-1:0]    req_ready,
  input  logic              [NUM_REQS-1:0]    req_last,
  input  risc_v_data_type_t [NUM_REQS-1:0]    req_data_type,
  input  risc_v_cacheline_t [NUM_REQS-1:0]    req_cacheline,
  VX_mem_load_if.master                       load_if,
  output logic                                busy,
  output logic              [IDX_W-1:0]       grant_id,
  output logic              [CNT_W-1:0]       xfer_count
);

  localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  mem_load_arb_state_e state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                load_valid_q, load_valid_d;
  risc_v_data_type_t   dtype_q, dtype_d;
  risc_v_cacheline_t   cl_q, cl_d;
  logic [CNT_W-1:0]    xfer_q, xfer_d;

  logic [IDX_W-1:0]    pick;
  logic                any_valid;
  logic                slot_free;
  logic                xfer;
  logic                burst_end;

  vx_rr_pick #(
    .NUM_REQS (NUM_REQS),
    .IDX_W    (IDX_W)
  ) u_pick (
    .valid_i (req_valid),
    .last_i  (grant_q),
    .pick_o  (pick),
    .any_o   (any_valid)
  );

  // Output register can take a new beat when empty or draining this cycle.
  assign slot_free = !load_valid_q || load_if.load_ready;
  assign burst_end = req_last[grant_q] ||
                     (beat_cnt_q == BCNT_W'(MAX_BURST - 1));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    xfer       = 1'b0;
    case (state_q)
      IDLE: begin
        // Arbitration bubble: the pick is registered, no beat moves.
        if (any_valid) begin
          grant_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A dropped req_valid only stalls the burst; the grant is kept.
        req_ready[grant_q] = slot_free;
        xfer               = req_valid[grant_q] && slot_free;
        if (xfer) begin
          if (burst_end) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: a capture wins over a drain, so drain+capture in one cycle
  // keeps load_valid high with the new beat. Without a capture the payload
  // is untouched, which keeps it stable while load_ready is low.
  always_comb begin
    load_valid_d = load_valid_q;
    dtype_d      = dtype_q;
    cl_d         = cl_q;
    if (xfer) begin
      load_valid_d = 1'b1;
      dtype_d      = req_data_type[grant_q];
      cl_d         = req_cacheline[grant_q];
    end else if (load_if.load_ready) begin
      load_valid_d = 1'b0;
    end
    xfer_d = xfer_q + CNT_W'(load_valid_q && load_if.load_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= IDX_W'(NUM_REQS - 1);  // requester 0 scanned first
      beat_cnt_q   <= '0;
      load_valid_q <= 1'b0;
      dtype_q      <= DT_INSTR;
      cl_q         <= '0;
      xfer_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      beat_cnt_q   <= beat_cnt_d;
      load_valid_q <= load_valid_d;
      dtype_q      <= dtype_d;
      cl_q         <= cl_d;
      xfer_q       <= xfer_d;
    end
  end

  assign load_if.load_valid = load_valid_q;
  assign load_if.data_type  = dtype_q;
  assign load_if.cacheline  = cl_q;

  assign busy       = (state_q == GRANT) || load_valid_q;
  assign grant_id   = grant_q;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_vx_mem_load_arb.sv
module tb_vx_mem_load_arb;
  import vx_mem_load_arb_pkg::*;

  localparam int NR = 2;
  localparam int MB = 4;
  localparam int CW = 32;

  typedef struct packed {
    risc_v_data_type_t dt;
    risc_v_cacheline_t cl;
    logic              last;
  } beat_t;

  logic                          clk = 1'b0;
  logic                          reset;
  logic              [NR-1:0]    req_valid;
  logic              [NR-1:0]    req_ready;
  logic              [NR-1:0]    req_last;
  risc_v_data_type_t [NR-1:0]    req_data_type;
  risc_v_cacheline_t [NR-1:0]    req_cacheline;
  logic                          busy;
  logic              [0:0]       grant_id;
  logic              [CW-1:0]    xfer_count;

  VX_mem_load_if load_if ();

  vx_mem_load_arb #(.NUM_REQS(NR), .MAX_BURST(MB), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_last      (req_last),
    .req_data_type (req_data_type),
    .req_cacheline (req_cacheline),
    .load_if       (load_if),
    .busy          (busy),
    .grant_id      (grant_id),
    .xfer_count    (xfer_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t rq0[$];
  beat_t rq1[$];
  beat_t exp_q[$];
  int    hs_q[$];
  int    stall0 = 0;
  int    rst_cnt = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  function automatic beat_t mk(input int r, input int i, input logic last);
    beat_t b;
    b.cl         = '0;
    b.cl[511:496] = 16'hA5C3;
    b.cl[15:8]   = 8'(r);
    b.cl[7:0]    = 8'(i);
    b.dt         = risc_v_data_type_t'(2'((r + i) % 4));
    b.last       = last;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Push beats for a requester and queue their expected delivery separately
  // (delivery order is hand-derived per test, so pushes to exp_q are explicit).
  task automatic add(input int r, input int i, input logic last);
    if (r == 0) rq0.push_back(mk(0, i, last));
    else        rq1.push_back(mk(1, i, last));
  endtask

  task automatic expect_beat(input int r, input int i);
    exp_q.push_back(mk(r, i, 1'b0));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rst_cnt++;
    rq0.delete(); rq1.delete(); exp_q.delete(); hs_q.delete();
    stall0 = 0;
    load_if.load_ready = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int k;
    k = 0;
    while ((rq0.size() != 0 || rq1.size() != 0 || exp_q.size() != 0 || busy) && k < maxc) begin
      tick(1);
      k++;
    end
    chk({name, "_drain_timeout"}, 64'(k >= maxc), 64'd0);
  endtask

  // Requester drivers: present the head beat at negedge, decide the
  // handshake just before the edge, retire the beat at the edge.
  initial begin
    logic f0, f1;
    req_valid = '0;
    req_last  = '0;
    req_data_type[0] = DT_INSTR;
    req_data_type[1] = DT_INSTR;
    req_cacheline = '0;
    forever begin
      @(negedge clk);
      if (stall0 > 0) begin
        req_valid[0] = 1'b0;
        stall0--;
      end else if (rq0.size() != 0) begin
        req_valid[0] = 1'b1;
        req_data_type[0] = rq0[0].dt;
        req_cacheline[0] = rq0[0].cl;
        req_last[0]      = rq0[0].last;
      end else begin
        req_valid[0] = 1'b0;
      end
      if (rq1.size() != 0) begin
        req_valid[1] = 1'b1;
        req_data_type[1] = rq1[0].dt;
        req_cacheline[1] = rq1[0].cl;
        req_last[1]      = rq1[0].last;
      end else begin
        req_valid[1] = 1'b0;
      end
      #4;
      f0 = req_valid[0] && req_ready[0];
      f1 = req_valid[1] && req_ready[1];
      @(posedge clk);
      if (f0 && rq0.size() != 0) void'(rq0.pop_front());
      if (f1 && rq1.size() != 0) void'(rq1.pop_front());
    end
  end

  // Monitor: pops the scoreboard on each loader handshake, checks hold
  // stability under backpressure and that no requester is acknowledged then.
  initial begin
    beat_t             e;
    logic              prev_stall;
    risc_v_cacheline_t prev_cl;
    risc_v_data_type_t prev_dt;
    int                seen_rst;
    prev_stall = 1'b0;
    prev_cl    = '0;
    prev_dt    = DT_INSTR;
    seen_rst   = 0;
    forever begin
      @(negedge clk);
      #4;
      if (seen_rst != rst_cnt || reset) begin
        prev_stall = 1'b0;
        seen_rst   = rst_cnt;
      end
      if (load_if.load_valid && load_if.load_ready) begin
        hs_q.push_back(cyc + 1);
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got %h expected none", load_if.cacheline);
        end else begin
          e = exp_q.pop_front();
          if (load_if.cacheline !== e.cl || load_if.data_type !== e.dt) begin
            n_fail++;
            $display("FAIL beat_data: got %h/%0d expected %h/%0d",
                     load_if.cacheline, load_if.data_type, e.cl, e.dt);
          end
        end
      end
      if (prev_stall) begin
        n_chk++;
        if (!load_if.load_valid || load_if.cacheline !== prev_cl || load_if.data_type !== prev_dt) begin
          n_fail++;
          $display("FAIL hold_stable: got v=%0d %h expected v=1 %h",
                   load_if.load_valid, load_if.cacheline, prev_cl);
        end
      end
      if (load_if.load_valid && !load_if.load_ready && !reset) begin
        n_chk++;
        if (req_ready !== '0) begin
          n_fail++;
          $display("FAIL ready_under_bp: got %b expected 00", req_ready);
        end
      end
      prev_stall = load_if.load_valid && !load_if.load_ready && !reset;
      prev_cl    = load_if.cacheline;
      prev_dt    = load_if.data_type;
    end
  end

  initial begin
    int c;
    int k;
    reset = 1'b1;
    load_if.load_ready = 1'b1;
    #3;
    chk("rst_load_valid", 64'(load_if.load_valid), 64'd0);
    chk("rst_req_ready",  64'(req_ready), 64'd0);
    chk("rst_busy",       64'(busy), 64'd0);
    chk("rst_grant_id",   64'(grant_id), 64'd1);
    chk("rst_xfer_count", 64'(xfer_count), 64'd0);
    do_reset();

    // Single requester, 3-beat burst: handshakes 3,4,5 edges after the push.
    c = cyc;
    for (int i = 0; i < 3; i++) begin add(0, i, i == 2); expect_beat(0, i); end
    tick(1);
    chk("single_grant", 64'(grant_id), 64'd0);
    chk("single_busy",  64'(busy), 64'd1);
    wait_drain("single", 40);
    chk("single_hs_n", 64'(hs_q.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < hs_q.size()) chk("single_latency", 64'(hs_q[i] - c), 64'(3 + i));
    chk("single_xfer", 64'(xfer_count), 64'd3);
    chk("single_grant_end", 64'(grant_id), 64'd0);

    // Fairness: two 1-beat bursts each, alternating from requester 0.
    do_reset();
    add(0, 0, 1'b1); add(0, 1, 1'b1);
    add(1, 0, 1'b1); add(1, 1, 1'b1);
    expect_beat(0, 0); expect_beat(1, 0); expect_beat(0, 1); expect_beat(1, 1);
    wait_drain("fair", 60);
    chk("fair_xfer", 64'(xfer_count), 64'd4);

    // Burst cap of 4: requester 1 is cut after 4 beats, 0 is served, then
    // 1 resumes. Its final beat closes the burst so the grant can drain.
    do_reset();
    for (int i = 0; i < 10; i++) add(1, i, i == 9);
    for (int i = 0; i < 4; i++) expect_beat(1, i);
    expect_beat(0, 0); expect_beat(0, 1);
    for (int i = 4; i < 10; i++) expect_beat(1, i);
    tick(2);
    add(0, 0, 1'b0); add(0, 1, 1'b1);
    tick(4);
    chk("cap_switch_grant", 64'(grant_id), 64'd0);
    wait_drain("cap", 100);
    chk("cap_xfer", 64'(xfer_count), 64'd12);

    // Backpressure for 5 cycles mid-burst.
    do_reset();
    for (int i = 0; i < 6; i++) begin add(0, i, i == 5); expect_beat(0, i); end
    tick(4);
    load_if.load_ready = 1'b0;
    tick(2);
    chk("bp_valid_held", 64'(load_if.load_valid), 64'd1);
    chk("bp_req_ready",  64'(req_ready), 64'd0);
    chk("bp_xfer_mid",   64'(xfer_count), 64'd2);
    tick(3);
    load_if.load_ready = 1'b1;
    wait_drain("bp", 60);
    chk("bp_xfer", 64'(xfer_count), 64'd6);

    // Async reset between edges while a beat is held.
    do_reset();
    for (int i = 0; i < 5; i++) begin add(0, i, i == 4); expect_beat(0, i); end
    k = 0;
    while (!load_if.load_valid && k < 20) begin tick(1); k++; end
    chk("ar_wait_timeout", 64'(k >= 20), 64'd0);
    tick(1);
    chk("ar_pre_xfer", 64'(xfer_count), 64'd1);
    #2;
    reset = 1'b1;
    rst_cnt++;
    rq0.delete(); rq1.delete(); exp_q.delete();
    #1;
    chk("ar_load_valid", 64'(load_if.load_valid), 64'd0);
    chk("ar_busy",       64'(busy), 64'd0);
    chk("ar_xfer",       64'(xfer_count), 64'd0);
    chk("ar_req_ready",  64'(req_ready), 64'd0);
    tick(2);
    reset = 1'b0;
    tick(1);
    add(0, 7, 1'b1); add(1, 7, 1'b1);
    expect_beat(0, 7); expect_beat(1, 7);
    tick(1);
    chk("ar_first_prio", 64'(grant_id), 64'd0);
    wait_drain("ar", 40);
    chk("ar_xfer_after", 64'(xfer_count), 64'd2);

    // Requester 0 stalls 3 cycles inside its grant; 1 waits for its last beat.
    do_reset();
    for (int i = 0; i < 4; i++) begin add(0, i, i == 3); expect_beat(0, i); end
    tick(2);
    stall0 = 3;
    add(1, 0, 1'b1);
    expect_beat(1, 0);
    tick(2);
    chk("stall_grant_held", 64'(grant_id), 64'd0);
    chk("stall_req_ready",  64'(req_ready), 64'b01);
    chk("stall_busy",       64'(busy), 64'd1);
    wait_drain("stall", 60);
    chk("stall_xfer", 64'(xfer_count), 64'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
